// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier's partial-product path.
package mult_pkg;

  localparam int NIB_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] STEP_LL = 2'd0;
  localparam logic [1:0] STEP_LH = 2'd1;
  localparam logic [1:0] STEP_HL = 2'd2;
  localparam logic [1:0] STEP_HH = 2'd3;

  // Cross terms share the single-nibble weight; hi*hi carries two nibbles.
  function automatic int unsigned pp_shift(input logic [1:0] idx, input int unsigned nib);
    case (idx)
      STEP_LL: pp_shift = 0;
      STEP_LH: pp_shift = nib;
      STEP_HL: pp_shift = nib;
      default: pp_shift = 2 * nib;
    endcase
  endfunction

endpackage

// File: rtl/pp_aligner.sv
// Zero-extends a partial product to product width and weights it by its step index.
module pp_aligner
  import mult_pkg::*;
#(
  parameter int NIB = NIB_DEF
) (
  input  logic [2*NIB-1:0] pp_data,
  input  logic [1:0]       pp_idx,
  output logic [4*NIB-1:0] term
);

  logic [4*NIB-1:0] w_ext;

  assign w_ext = {{(2*NIB){1'b0}}, pp_data};
  assign term  = w_ext << pp_shift(pp_idx, NIB);

endmodule

// File: rtl/mult_pp_accumulator.sv
// Accumulates the four ordered partial products of a sequential multiply and
// presents the finished product on a valid/ready handshake.
module mult_pp_accumulator
  import mult_pkg::*;
#(
  parameter int NIB = NIB_DEF
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             start,
  input  logic             pp_valid,
  input  logic [1:0]       pp_idx,
  input  logic [2*NIB-1:0] pp_data,
  output logic             prod_valid,
  input  logic             prod_ready,
  output logic [4*NIB-1:0] product,
  output logic             busy,
  output logic             seq_err
);

  state_t           r_state;
  logic [4*NIB-1:0] r_acc;
  logic [1:0]       r_exp_idx;
  logic [4*NIB-1:0] r_prod;
  logic             r_prod_valid;
  logic             r_busy;
  logic             r_seq_err;

  logic [4*NIB-1:0] w_term;
  logic [4*NIB-1:0] w_sum;

  pp_aligner #(.NIB(NIB)) u_aligner (
    .pp_data (pp_data),
    .pp_idx  (pp_idx),
    .term    (w_term)
  );

  // Carry-out is dropped: four valid nibble products always fit.
  assign w_sum = r_acc + w_term;

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_exp_idx    <= STEP_LL;
      r_prod       <= '0;
      r_prod_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_seq_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= ACCUM;
            r_acc     <= '0;
            r_exp_idx <= STEP_LL;
            r_seq_err <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        ACCUM: begin
          // A restart wins over any beat presented in the same cycle.
          if (start) begin
            r_acc     <= '0;
            r_exp_idx <= STEP_LL;
          end else if (pp_valid) begin
            if (pp_idx == r_exp_idx) begin
              if (pp_idx == STEP_HH) begin
                r_prod       <= w_sum;
                r_prod_valid <= 1'b1;
                r_busy       <= 1'b0;
                r_state      <= HOLD;
              end else begin
                r_acc     <= w_sum;
                r_exp_idx <= r_exp_idx + 2'd1;
              end
            end else begin
              r_seq_err <= 1'b1;
              r_acc     <= '0;
              r_exp_idx <= STEP_LL;
              r_busy    <= 1'b0;
              r_state   <= IDLE;
            end
          end
        end
        HOLD: begin
          if (prod_ready) begin
            r_prod_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_prod_valid <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign prod_valid = r_prod_valid;
  assign product    = r_prod;
  assign busy       = r_busy;
  assign seq_err    = r_seq_err;

endmodule

// File: doc/mult_pp_accumulator.md
# mult_pp_accumulator

Consumer end of the sequential 8x8 multiplier's 2-bit step counter. For each step index it receives the 4x4 partial product from the datapath, aligns it by the shift that index implies, and accumulates the 16-bit product. It checks that steps arrive in counter order 0→1→2→3, then presents the finished product on a valid/ready output handshake.

## Interface
- NIB, default 4: nibble width. Partial product is 2*NIB bits; product is 4*NIB bits.
- clk  in  1  system clock, rising edge.
- aclr_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a new multiply (clears the accumulator and expected index).
- pp_valid  in  1  partial product presented this cycle.
- pp_idx  in  2  step index from the counter: 0=lo·lo, 1=alo·bhi, 2=ahi·blo, 3=hi·hi.
- pp_data  in  2*NIB  partial product.
- prod_valid  out  1  product available.
- prod_ready  in  1  downstream accepts the product.
- product  out  4*NIB  accumulated result.
- busy  out  1  high in ACCUM.
- seq_err  out  1  sticky out-of-order flag; cleared by the next accepted start.

## Operation
- State machine:
  - IDLE: start → ACCUM; acc=0, exp_idx=0, seq_err=0. pp_valid ignored.
  - ACCUM: on pp_valid with pp_idx==exp_idx: acc += pp_data << shift(pp_idx); exp_idx++.
    - Accepting idx 3 → HOLD; product is loaded with the final sum.
    - pp_valid with pp_idx≠exp_idx → seq_err=1, acc discarded, go to IDLE, prod_valid never asserts.
    - start in ACCUM restarts: acc=0, exp_idx=0, stay in ACCUM; a pp_valid in the same cycle is ignored.
  - HOLD: prod_valid=1 and product stable until prod_valid&&prod_ready, then IDLE. start and pp_valid are ignored in HOLD.
- Shift amounts: shift(0)=0, shift(1)=NIB, shift(2)=NIB, shift(3)=2*NIB.
- Arithmetic: unsigned, 4*NIB-bit adder. The sum cannot overflow for valid 4x4 products, and no carry-out is kept.
- Reset mid-operation: everything returns to IDLE immediately and asynchronously. Any partial sum is lost.

## Timing
- Reset values: prod_valid=0, product=0, busy=0, seq_err=0, state=IDLE, acc=0, exp_idx=0.
- Throughput: one partial product per cycle. Gaps between pp_valid beats are allowed.
- Latency: prod_valid rises on the clock edge that accepts idx 3, so it is visible the cycle after the idx-3 beat.
- busy rises the cycle after start and falls the same edge prod_valid rises.
- Handshake: the product is transferred on the edge where prod_valid&&prod_ready.
  - prod_ready may be held high in advance; the minimum HOLD occupancy is then 1 cycle.
  - The earliest next start is accepted the cycle after the transfer.
- seq_err sets on the edge of the offending beat and holds until the next start is taken in IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package (mult_pkg):
  - state enum {IDLE, ACCUM, HOLD}.
  - NIB default.
  - Step-index constants STEP_LL/LH/HL/HH.
  - shift function or constant array indexed by step.
- One sub-module, pp_aligner: combinational; pp_data and pp_idx in, zero-extended shifted 4*NIB term out. The accumulator FSM instantiates it once.

## Test plan
- Reset then A=0xAB, B=0xCD: start, then beats idx0..3 = 0x8F, 0x84, 0x82, 0x78 on consecutive cycles, prod_ready=1 → prod_valid for 1 cycle with product=0x88EF; busy high for 4 cycles.
- A=B=0xFF: beats 0xE1 ×4 with one idle cycle between each, prod_ready=0 for 3 cycles → product=0xFE01 held stable while prod_valid=1; transfer on the first ready cycle, then IDLE.
- Out of order: start, idx0=0x10, then idx2=0x20 → seq_err=1 next cycle, busy=0, prod_valid stays 0. The next start clears seq_err.
- Restart: start, idx0, idx1, then start again, then a full 0xAB×0xCD sequence → product=0x88EF; the first partial sum is discarded.
- Ignored inputs: pp_valid beats in IDLE and start pulses in HOLD → no state change, product unchanged.
- Async reset: assert aclr_n=0 between clock edges during ACCUM after idx1 → all outputs 0 immediately. After release, a full sequence yields the correct product.
